sram_pattern_tester: RTL and testbench
======================================

SRAM_PATTERN_TESTER -- requirements
Module: sram_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20, SRAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, SRAM data and pattern width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run; honoured only in IDLE, DONE or FAIL.
REQ-006 SHALL have port pattern  input  DATA_BITS  current test pattern from the pattern source.
REQ-007 SHALL have port pattern_last  input  1  high when the current pattern is the final one.
REQ-008 SHALL have port pattern_reset  output  1  one-cycle pulse returning the pattern source to its first pattern.
REQ-009 SHALL have port pattern_inc  output  1  one-cycle pulse advancing the pattern source.
REQ-010 SHALL have port mem_req  output  1  SRAM controller request valid.
REQ-011 SHALL have port mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-012 SHALL have port mem_addr  output  ADDR_BITS  request address.
REQ-013 SHALL have port mem_wdata  output  DATA_BITS  write data.
REQ-014 SHALL have port mem_ready  input  1  controller accepts request when mem_req && mem_ready.
REQ-015 SHALL have port mem_rvalid  input  1  read data valid, one cycle.
REQ-016 SHALL have port mem_rdata  input  DATA_BITS  read data.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE, DONE or FAIL.
REQ-018 SHALL have port done  output  1  sticky; run completed with all patterns passing.
REQ-019 SHALL have port fail  output  1  sticky; mismatch detected.
REQ-020 SHALL have port fail_addr, fail_expected, fail_actual  output  ADDR_BITS/DATA_BITS/DATA_BITS  address, pattern and read data captured at the first mismatch.

Function
REQ-021 SHALL implement FSM states IDLE, INIT, WRITE, READ, READ_WAIT, NEXT, DONE, FAIL.
REQ-022 SHALL, in IDLE/DONE/FAIL with start=1, pulse pattern_reset, clear done/fail/fail_*, zero the address counter and enter INIT.
REQ-023 SHALL remain in INIT for exactly one cycle, giving the pattern source time to settle, then enter WRITE.
REQ-024 SHALL, in WRITE, drive mem_req=1, mem_we=1, mem_addr=counter, mem_wdata=pattern, and hold them stable until accepted.
REQ-025 SHALL, on an accepted write, increment the address; on acceptance at all-ones the address SHALL wrap to 0 and the FSM SHALL enter READ.
REQ-026 SHALL, in READ, drive mem_req=1, mem_we=0, mem_addr=counter until accepted, then enter READ_WAIT with mem_req=0.
REQ-027 SHALL allow exactly one read outstanding; responses are matched to the held address.
REQ-028 SHALL, in READ_WAIT on mem_rvalid, compare mem_rdata with pattern across all DATA_BITS.
REQ-029 SHALL, on mismatch, capture fail_addr, fail_expected and fail_actual, set fail and enter FAIL.
REQ-030 SHALL, on match at an address other than all-ones, increment the address and return to READ.
REQ-031 SHALL, on match at all-ones, wrap the address to 0 and enter NEXT.
REQ-032 SHALL, in NEXT, enter DONE and set done if pattern_last=1; otherwise pulse pattern_inc for one cycle and enter INIT.
REQ-033 SHALL keep mem_req=0 in IDLE, INIT, READ_WAIT, NEXT, DONE and FAIL.
REQ-034 SHALL ignore mem_rvalid outside READ_WAIT.
REQ-035 SHALL ignore start while busy=1.
REQ-036 SHALL never assert done and fail together.

Reset
REQ-037 SHALL, on reset, enter IDLE and drive mem_req, pattern_inc, pattern_reset, done, fail, busy and fail_* to 0 and zero the address counter, including mid-transaction.
REQ-038 SHALL abandon any outstanding read on reset without waiting for mem_rvalid.

Structure
REQ-039 SHALL declare the FSM state enum in the shared package sram_test_pkg.
REQ-040 SHALL place the address counter with wrap detection (last flag) in sub-module sram_addr_counter.

Verification (ADDR_BITS=3, DATA_BITS=16, behavioural SRAM model; random mem_ready unless noted)
REQ-041 SHALL verify: start with 7 patterns, ideal memory -> 8 writes then 8 reads per pattern, 6 pattern_inc pulses, done=1, fail=0.
REQ-042 SHALL verify: model corrupts bit 0 of address 5 during pattern 0xFFFF -> fail=1, fail_addr=5, fail_expected=0xFFFF, fail_actual=0xFFFE, no further mem_req.
REQ-043 SHALL verify: mem_ready held low 10 cycles while in WRITE -> mem_addr and mem_wdata unchanged across all 10 cycles, exactly one write per address.
REQ-044 SHALL verify: reset asserted in READ_WAIT before mem_rvalid, then a late mem_rvalid -> IDLE, all outputs 0, late response ignored.
REQ-045 SHALL verify: start pulsed while busy -> ignored; start pulsed in DONE -> pattern_reset pulse, done cleared, new run.

Source files
------------

// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM pattern tester.
//   state_e        : tester FSM states
//   state_is_busy  : true for every state in which a run is in progress
package sram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WRITE,
    READ,
    READ_WAIT,
    NEXT,
    DONE,
    FAIL
  } state_e;

  // IDLE, DONE and FAIL are the resting states; start is only honoured there.
  function automatic logic state_is_busy(input state_e s);
    return !(s == IDLE || s == DONE || s == FAIL);
  endfunction

endpackage

// File: rtl/sram_pattern_tester_if.sv
// Request/response bus between the pattern tester and an SRAM controller.
//   mem_req/mem_we/mem_addr/mem_wdata : request, held until mem_req && mem_ready
//   mem_ready                         : controller accepts the request this cycle
//   mem_rvalid/mem_rdata              : one-cycle read response
// master = tester side, slave = controller side.
interface sram_pattern_tester_if #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) ();

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/sram_addr_counter.sv
// Address counter for the pattern tester.
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : return the counter to 0 (takes priority over inc_i)
//   inc_i      : advance by one; all-ones wraps naturally to 0
//   addr_o     : current address
//   last_o     : high while the address is all-ones (final location)
module sram_addr_counter #(
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 inc_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o
);

  logic [ADDR_BITS-1:0] count_q;
  logic [ADDR_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + ADDR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign addr_o = count_q;
  assign last_o = &count_q;

endmodule

// File: rtl/sram_pattern_tester.sv
// SRAM pattern tester: for every pattern supplied by an external pattern
// source, writes the pattern to every address, then reads every address
// back and compares. Stops at the first mismatch (fail) or after the last
// pattern passes (done).
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a run (honoured only when not busy)
//   pattern           : current pattern from the source
//   pattern_last      : current pattern is the final one
//   pattern_reset     : pulse, rewind the source to its first pattern
//   pattern_inc       : pulse, advance the source
//   mem               : SRAM controller bus (master side)
//   busy/done/fail    : status; done and fail are sticky until next start
//   fail_addr/_expected/_actual : captured at the first mismatch
module sram_pattern_tester
  import sram_test_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_BITS-1:0]  pattern,
  input  logic                  pattern_last,
  output logic                  pattern_reset,
  output logic                  pattern_inc,
  sram_pattern_tester_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [DATA_BITS-1:0]  fail_expected,
  output logic [DATA_BITS-1:0]  fail_actual
);

  state_e               state_q, state_d;
  logic                 pattern_reset_q, pattern_reset_d;
  logic                 pattern_inc_q, pattern_inc_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_BITS-1:0] fail_expected_q, fail_expected_d;
  logic [DATA_BITS-1:0] fail_actual_q, fail_actual_d;

  logic                 cnt_clear;
  logic                 cnt_inc;
  logic [ADDR_BITS-1:0] cnt_addr;
  logic                 cnt_last;
  logic                 mem_req_c;
  logic                 mem_we_c;

  sram_addr_counter #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .addr_o  (cnt_addr),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d         = state_q;
    pattern_reset_d = 1'b0;
    pattern_inc_d   = 1'b0;
    done_d          = done_q;
    fail_d          = fail_q;
    fail_addr_d     = fail_addr_q;
    fail_expected_d = fail_expected_q;
    fail_actual_d   = fail_actual_q;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
    mem_req_c       = 1'b0;
    mem_we_c        = 1'b0;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          pattern_reset_d = 1'b1;
          done_d          = 1'b0;
          fail_d          = 1'b0;
          fail_addr_d     = '0;
          fail_expected_d = '0;
          fail_actual_d   = '0;
          cnt_clear       = 1'b1;
          state_d         = INIT;
        end
      end

      // The registered pattern_reset/pattern_inc pulse is visible to the
      // source during this cycle, so the new pattern is valid in WRITE.
      INIT: begin
        state_d = WRITE;
      end

      WRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        if (mem.mem_ready) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = READ;
          end
        end
      end

      READ: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          state_d = READ_WAIT;
        end
      end

      // Only one read is ever outstanding, so the response belongs to the
      // address still held in the counter.
      READ_WAIT: begin
        if (mem.mem_rvalid) begin
          if (mem.mem_rdata != pattern) begin
            fail_d          = 1'b1;
            fail_addr_d     = cnt_addr;
            fail_expected_d = pattern;
            fail_actual_d   = mem.mem_rdata;
            state_d         = FAIL;
          end else begin
            cnt_inc = 1'b1;
            state_d = cnt_last ? NEXT : READ;
          end
        end
      end

      NEXT: begin
        if (pattern_last) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          pattern_inc_d = 1'b1;
          state_d       = INIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pattern_reset_q <= 1'b0;
      pattern_inc_q   <= 1'b0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q         <= state_d;
      pattern_reset_q <= pattern_reset_d;
      pattern_inc_q   <= pattern_inc_d;
      done_q          <= done_d;
      fail_q          <= fail_d;
      fail_addr_q     <= fail_addr_d;
      fail_expected_q <= fail_expected_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_we    = mem_we_c;
  assign mem.mem_addr  = cnt_addr;
  assign mem.mem_wdata = pattern;

  assign pattern_reset = pattern_reset_q;
  assign pattern_inc   = pattern_inc_q;
  assign busy          = state_is_busy(state_q);
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester with an 8-word behavioural SRAM, a table
// driven pattern source and random ready/latency on the memory bus.
module tb_sram_pattern_tester;

  localparam int AB     = 3;
  localparam int DB     = 16;
  localparam int DEPTH  = 8;
  localparam int MAXPAT = 7;
  localparam int NVEC   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DB-1:0] pattern;
  logic          pattern_last;
  logic          pattern_reset;
  logic          pattern_inc;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AB-1:0] fail_addr;
  logic [DB-1:0] fail_expected;
  logic [DB-1:0] fail_actual;

  sram_pattern_tester_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

  sram_pattern_tester #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .pattern_last  (pattern_last),
    .pattern_reset (pattern_reset),
    .pattern_inc   (pattern_inc),
    .mem           (mem_if),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- pattern source ----------------
  logic [DB-1:0] pat_tab [MAXPAT];
  int            num_pat = 1;
  int            pat_idx = 0;

  always @(posedge clk) begin
    if (pattern_reset) pat_idx <= 0;
    else if (pattern_inc) pat_idx <= pat_idx + 1;
  end

  assign pattern      = (pat_idx < MAXPAT) ? pat_tab[pat_idx] : '0;
  assign pattern_last = (pat_idx == num_pat - 1);

  // ---------------- behavioural SRAM + monitor ----------------
  logic [DB-1:0] mem_arr [DEPTH];
  int            wr_count, rd_count, inc_count, prst_count;
  int            wr_per_addr [DEPTH];
  bit            count_en     = 0;
  bit            rd_pending   = 0;
  int            rd_delay     = 0;
  logic [AB-1:0] rd_addr      = '0;
  bit            hold_resp    = 0;
  bit            late_resp    = 0;
  bit            spurious_en  = 0;
  bit            stall_armed  = 0;
  int            stall_cycles = 0;
  logic [AB-1:0] stall_addr;
  logic [DB-1:0] stall_wdata;
  bit            corrupt_en   = 0;
  int            corrupt_pat  = 0;
  logic [AB-1:0] corrupt_addr = '0;
  logic [DB-1:0] corrupt_mask = '0;

  // Inputs change on the falling edge; the request seen here is the one
  // the DUT presents at the next rising edge.
  always @(negedge clk) begin
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    if (rd_pending && !hold_resp) begin
      if (rd_delay == 0) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = mem_arr[rd_addr];
        rd_pending        = 0;
      end else begin
        rd_delay--;
      end
    end else if (late_resp) begin
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = ~pattern;
      late_resp         = 0;
      rd_pending        = 0;
    end else if (!rd_pending && spurious_en && $urandom_range(0, 7) == 0) begin
      // stray response while no read is outstanding; must be ignored
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = ~pattern;
    end

    if (stall_cycles > 0) begin
      mem_if.mem_ready = 1'b0;
      chk("stall_req", 32'(mem_if.mem_req), 32'd1);
      chk("stall_addr", 32'(mem_if.mem_addr), 32'(stall_addr));
      chk("stall_wdata", 32'(mem_if.mem_wdata), 32'(stall_wdata));
      stall_cycles--;
    end else if (stall_armed && mem_if.mem_req && mem_if.mem_we) begin
      stall_armed      = 0;
      stall_addr       = mem_if.mem_addr;
      stall_wdata      = mem_if.mem_wdata;
      mem_if.mem_ready = 1'b0;
      stall_cycles     = 9;
    end else begin
      mem_if.mem_ready = ($urandom_range(0, 3) != 0);
    end

    if (count_en) begin
      if (mem_if.mem_req && mem_if.mem_ready) begin
        if (mem_if.mem_we) begin
          chk("wr_addr", 32'(mem_if.mem_addr), 32'(wr_count % DEPTH));
          if (wr_count / DEPTH < MAXPAT)
            chk("wr_data", 32'(mem_if.mem_wdata), 32'(pat_tab[wr_count / DEPTH]));
          if (corrupt_en && (wr_count / DEPTH == corrupt_pat) && mem_if.mem_addr == corrupt_addr)
            mem_arr[mem_if.mem_addr] = mem_if.mem_wdata ^ corrupt_mask;
          else
            mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
          wr_per_addr[mem_if.mem_addr]++;
          wr_count++;
        end else begin
          chk("rd_addr", 32'(mem_if.mem_addr), 32'(rd_count % DEPTH));
          rd_pending = 1;
          rd_delay   = $urandom_range(0, 3);
          rd_addr    = mem_if.mem_addr;
          rd_count++;
        end
      end
      if (pattern_inc) inc_count++;
      if (pattern_reset) prst_count++;
    end
  end

  // ---------------- vectors and reference model ----------------
  typedef struct {
    int                       n;
    logic [MAXPAT-1:0][DB-1:0] pats;
    bit                       c_en;
    int                       c_pat;
    logic [AB-1:0]            c_addr;
    logic [DB-1:0]            c_mask;
    bit                       stall;
    bit                       busy_start;
    int                       exp_wr, exp_rd, exp_inc;
    bit                       exp_done, exp_fail;
    logic [AB-1:0]            exp_fa;
    logic [DB-1:0]            exp_fe, exp_fact;
  } vec_t;

  vec_t vecs [NVEC];

  // Outcome of a run: a corrupted word in pattern k at address a stops the
  // run during the read-back of pattern k, right after reading address a.
  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    if (v.c_en && v.c_pat < v.n) begin
      r.exp_wr   = DEPTH * (v.c_pat + 1);
      r.exp_rd   = DEPTH * v.c_pat + int'(v.c_addr) + 1;
      r.exp_inc  = v.c_pat;
      r.exp_done = 0;
      r.exp_fail = 1;
      r.exp_fa   = v.c_addr;
      r.exp_fe   = v.pats[v.c_pat];
      r.exp_fact = v.pats[v.c_pat] ^ v.c_mask;
    end else begin
      r.exp_wr   = DEPTH * v.n;
      r.exp_rd   = DEPTH * v.n;
      r.exp_inc  = v.n - 1;
      r.exp_done = 1;
      r.exp_fail = 0;
      r.exp_fa   = '0;
      r.exp_fe   = '0;
      r.exp_fact = '0;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int cycles;
    int post_req;
    for (int i = 0; i < MAXPAT; i++) pat_tab[i] = v.pats[i];
    num_pat      = v.n;
    corrupt_en   = v.c_en;
    corrupt_pat  = v.c_pat;
    corrupt_addr = v.c_addr;
    corrupt_mask = v.c_mask;
    stall_armed  = v.stall;
    wr_count = 0; rd_count = 0; inc_count = 0; prst_count = 0;
    for (int i = 0; i < DEPTH; i++) wr_per_addr[i] = 0;
    spurious_en = 1;
    count_en    = 1;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_prst", 32'(pattern_reset), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clr", {30'd0, done, fail}, 32'd0);

    cycles = 0;
    while (!(done || fail) && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      start = (v.busy_start && (cycles == 15 || cycles == 40));
    end
    start = 1'b0;
    if (cycles >= 5000) chk("run_timeout", 32'(cycles), 32'd0);

    chk("done", 32'(done), 32'(v.exp_done));
    chk("fail", 32'(fail), 32'(v.exp_fail));
    chk("done_and_fail", 32'(done & fail), 32'd0);
    chk("fail_addr", 32'(fail_addr), 32'(v.exp_fa));
    chk("fail_expected", 32'(fail_expected), 32'(v.exp_fe));
    chk("fail_actual", 32'(fail_actual), 32'(v.exp_fact));
    chk("writes", 32'(wr_count), 32'(v.exp_wr));
    chk("reads", 32'(rd_count), 32'(v.exp_rd));
    chk("pattern_incs", 32'(inc_count), 32'(v.exp_inc));
    chk("pattern_resets", 32'(prst_count), 32'd1);
    if (v.exp_done)
      for (int i = 0; i < DEPTH; i++) chk("writes_per_addr", 32'(wr_per_addr[i]), 32'(v.n));

    post_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_if.mem_req) post_req++;
    end
    chk("post_req", 32'(post_req), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    count_en    = 0;
    spurious_en = 0;
    $display("vec %0d: patterns=%0d writes=%0d reads=%0d incs=%0d done=%0b fail=%0b addr=%0d exp=0x%0h act=0x%0h",
             id, v.n, wr_count, rd_count, inc_count, done, fail, fail_addr, fail_expected, fail_actual);
  endtask

  task automatic reset_in_read_wait();
    int cycles;
    pat_tab[0]  = 16'hA5A5;
    num_pat     = 1;
    corrupt_en  = 0;
    hold_resp   = 1;
    wr_count = 0; rd_count = 0;
    count_en    = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    while (!rd_pending && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 500) chk("rw_timeout", 32'(cycles), 32'd0);
    @(negedge clk);  // read accepted; DUT now waiting for the response
    chk("rw_busy", 32'(busy), 32'd1);
    chk("rw_req", 32'(mem_if.mem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_fail", {30'd0, done, fail}, 32'd0);
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_pulses", {30'd0, pattern_inc, pattern_reset}, 32'd0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_fail_fields", 32'(fail_addr) | 32'(fail_expected) | 32'(fail_actual), 32'd0);
    late_resp = 1;
    cycles = 0;
    while (late_resp && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_fail", 32'(fail), 32'd0);
    chk("late_req", 32'(mem_if.mem_req), 32'd0);
    hold_resp = 0;
    count_en  = 0;
    $display("reset-in-read-wait: reads=%0d busy=%0b fail=%0b", rd_count, busy, fail);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < MAXPAT; i++) pat_tab[i] = '0;

    // fixed rows
    vecs[0] = '{n: 7, pats: '0, c_en: 0, c_pat: 0, c_addr: '0, c_mask: '0, stall: 0,
                busy_start: 0, exp_wr: 56, exp_rd: 56, exp_inc: 6, exp_done: 1,
                exp_fail: 0, exp_fa: '0, exp_fe: '0, exp_fact: '0};
    vecs[0].pats[0] = 16'h0000; vecs[0].pats[1] = 16'hFFFF; vecs[0].pats[2] = 16'hAAAA;
    vecs[0].pats[3] = 16'h5555; vecs[0].pats[4] = 16'h00FF; vecs[0].pats[5] = 16'hFF00;
    vecs[0].pats[6] = 16'h0F0F;
    vecs[1] = vecs[0];
    vecs[1].c_en = 1; vecs[1].c_pat = 1; vecs[1].c_addr = 3'd5; vecs[1].c_mask = 16'h0001;
    vecs[1].exp_wr = 16; vecs[1].exp_rd = 14; vecs[1].exp_inc = 1; vecs[1].exp_done = 0;
    vecs[1].exp_fail = 1; vecs[1].exp_fa = 3'd5; vecs[1].exp_fe = 16'hFFFF;
    vecs[1].exp_fact = 16'hFFFE;
    vecs[2] = vecs[0];
    vecs[2].n = 2; vecs[2].stall = 1; vecs[2].busy_start = 1;
    vecs[2].exp_wr = 16; vecs[2].exp_rd = 16; vecs[2].exp_inc = 1;
    // random rows, expectations from the model
    for (int r = 3; r < NVEC; r++) begin
      vecs[r]        = vecs[0];
      vecs[r].n      = $urandom_range(1, MAXPAT);
      for (int i = 0; i < MAXPAT; i++) vecs[r].pats[i] = DB'($urandom);
      vecs[r].c_en   = (r != 3) && ($urandom_range(0, 3) != 0);
      vecs[r].c_pat  = $urandom_range(0, vecs[r].n - 1);
      vecs[r].c_addr = AB'($urandom_range(0, DEPTH - 1));
      vecs[r].c_mask = DB'($urandom_range(1, 16'hFFFF));
      vecs[r]        = model_expect(vecs[r]);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done_fail", {30'd0, done, fail}, 32'd0);
    chk("reset_req", 32'(mem_if.mem_req), 32'd0);
    chk("reset_pulses", {30'd0, pattern_inc, pattern_reset}, 32'd0);
    chk("reset_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("reset_fail_fields", 32'(fail_addr) | 32'(fail_expected) | 32'(fail_actual), 32'd0);

    for (int r = 0; r < 3; r++) run_vec(vecs[r], r);
    reset_in_read_wait();
    for (int r = 3; r < NVEC; r++) run_vec(vecs[r], r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
